// File: rtl/button_event.sv
// Turns a debounced switch level into single-cycle press/release/long/repeat
// events plus a "held" level, with an enable that clears all tracking.
module button_event #(
    parameter int WIDTH  = 24,
    parameter int HOLD   = 12_000_000,
    parameter int REPEAT = 3_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    input  logic en,
    output logic press,
    output logic release_pulse,
    output logic long,
    output logic rpt,
    output logic held
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DOWN = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    localparam logic [WIDTH-1:0] HOLD_LAST   = WIDTH'(HOLD - 1);
    localparam logic [WIDTH-1:0] REPEAT_LAST = WIDTH'((REPEAT > 0) ? (REPEAT - 1) : 0);
    localparam bit               REPEAT_ON   = (REPEAT != 0);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             held_q, held_d;

    logic rise;
    logic fall;

    assign rise = in & ~prev_q;
    assign fall = ~in & prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = in;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;
        held_d    = held_q;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    held_d = 1'b0;
                    // Counter starts at 0 on the press cycle so long lands HOLD cycles later.
                    if (rise) begin
                        press_d = 1'b1;
                        state_d = DOWN;
                        held_d  = 1'b1;
                    end
                end
                DOWN: begin
                    if (fall) begin
                        release_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                        held_d    = 1'b0;
                    end else if (cnt_q == HOLD_LAST) begin
                        long_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        release_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                        held_d    = 1'b0;
                    end else if (!REPEAT_ON) begin
                        cnt_d = '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        rpt_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
            held_q    <= held_d;
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long          = long_q;
    assign rpt           = rpt_q;
    assign held          = held_q;

endmodule
